// File: rtl/jt900h_muldiv_if.sv
// Start/busy/done handshake bundle between the control unit and the multiply/divide unit.
interface jt900h_muldiv_if #(
    parameter int DW = 16
);
    logic            start;
    logic [1:0]      op;
    logic            byte_op;
    logic [2*DW-1:0] op0;
    logic [DW-1:0]   op1;
    logic            busy;
    logic            done;
    logic [2*DW-1:0] dout;
    logic            v;

    modport master (output start, op, byte_op, op0, op1, input busy, done, dout, v);
    modport slave  (input start, op, byte_op, op0, op1, output busy, done, dout, v);
endinterface

// File: rtl/jt900h_muldiv.sv
// Iterative multiply/divide unit (MUL, MULS, DIV, DIVS at byte or word width) for the TLCS-900H.
// Define JT900H_MULDIV_FAST_EN to resolve MUL/MULS with one combinational W x W multiplier.
module jt900h_muldiv #(
    parameter int DW    = 16,
    parameter int RADIX = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    jt900h_muldiv_if.slave mdu
);
    localparam int CW = $clog2(DW + 1);
`ifdef JT900H_MULDIV_FAST_EN
    localparam logic MUL_SKIP = 1'b1;
`else
    localparam logic MUL_SKIP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, last;
    logic            done_q, done_d, v_q, v_d;
    logic [2*DW-1:0] dout_q, dout_d;
    logic            load, step, fix;

    logic            div_q, sgn_q, b8_q, neg_q, rneg_q, ovf_q, dz_q, skip_q;
    logic [DW-1:0]   rlo_q;
    logic [2*DW-1:0] a_q, a_d;     // multiplicand shifting left, or divisor magnitude
    logic [DW-1:0]   b_q, b_d;     // multiplier shifting right, or dividend low half becoming quotient
    logic [2*DW-1:0] acc_q, acc_d; // product, or partial remainder

    function automatic logic [DW-1:0] fit_w(input logic [DW-1:0] x, input logic b8);
        return b8 ? (x & DW'(8'hFF)) : x;
    endfunction

    function automatic logic [2*DW-1:0] fit_2w(input logic [2*DW-1:0] x, input logic b8);
        return b8 ? (x & (2*DW)'(16'hFFFF)) : x;
    endfunction

    function automatic logic [DW-1:0] neg_w(input logic [DW-1:0] x, input logic n, input logic b8);
        return fit_w(n ? (~x + DW'(1)) : x, b8);
    endfunction

    function automatic logic [2*DW-1:0] neg_2w(input logic [2*DW-1:0] x, input logic n, input logic b8);
        return fit_2w(n ? (~x + (2*DW)'(1)) : x, b8);
    endfunction

    logic            in_b8, in_sgn, in_div, sa, sb, sd;
    logic [DW-1:0]   ma, mb, dhi, dlo;
    logic [2*DW-1:0] md;

    // Operand magnitudes; the byte dividend low half is left-aligned so quotient bits land in [7:0]
    always_comb begin
        in_b8  = mdu.byte_op;
        in_sgn = mdu.op[0];
        in_div = mdu.op[1];
        sa     = in_sgn & (in_b8 ? mdu.op0[7]  : mdu.op0[DW-1]);
        sb     = in_sgn & (in_b8 ? mdu.op1[7]  : mdu.op1[DW-1]);
        sd     = in_sgn & (in_b8 ? mdu.op0[15] : mdu.op0[2*DW-1]);
        ma     = neg_w(mdu.op0[DW-1:0], sa, in_b8);
        mb     = neg_w(mdu.op1, sb, in_b8);
        md     = neg_2w(mdu.op0, sd, in_b8);
        dhi    = in_b8 ? DW'(md[15:8]) : md[2*DW-1:DW];
        dlo    = in_b8 ? (DW'(md[7:0]) << (DW - 8)) : md[DW-1:0];
    end

    logic [DW:0] rem;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        rem   = '0;
        if (load) begin
            a_d   = in_div ? (2*DW)'(mb) : (2*DW)'(ma);
            b_d   = in_div ? dlo : mb;
            acc_d = in_div ? (2*DW)'(dhi) : '0;
        end else if (step) begin
            for (int r = 0; r < RADIX; r++) begin
                if (div_q) begin
                    rem = {acc_d[DW-1:0], b_d[DW-1]};
                    b_d = b_d << 1;
                    if (rem >= {1'b0, a_d[DW-1:0]}) begin
                        rem    = rem - {1'b0, a_d[DW-1:0]};
                        b_d[0] = 1'b1;
                    end
                    acc_d = (2*DW)'(rem);
                end else begin
                    if (b_d[0]) acc_d = acc_d + a_d;
                    a_d = a_d << 1;
                    b_d = b_d >> 1;
                end
            end
        end
    end

    logic [2*DW-1:0] prod;
    logic [DW-1:0]   qm, rm, q, r;
    logic            qtop, qlowz, sovf;

    // Sign fix-up; a negative quotient may reach -2^(W-1), a positive one only 2^(W-1)-1
    always_comb begin
`ifdef JT900H_MULDIV_FAST_EN
        prod = (2*DW)'(a_q[DW-1:0]) * (2*DW)'(b_q);
`else
        prod = acc_q;
`endif
        qm     = fit_w(b_q, b8_q);
        rm     = fit_w(acc_q[DW-1:0], b8_q);
        q      = neg_w(qm, neg_q, b8_q);
        r      = neg_w(rm, rneg_q, b8_q);
        qtop   = b8_q ? qm[7] : qm[DW-1];
        qlowz  = b8_q ? (qm[6:0] == 7'd0) : (qm[DW-2:0] == '0);
        sovf   = neg_q ? (qtop & ~qlowz) : qtop;
        dout_d = dout_q;
        v_d    = v_q;
        if (fix) begin
            if (!div_q) begin
                dout_d = neg_2w(prod, neg_q, b8_q);
                v_d    = 1'b0;
            end else if (dz_q) begin
                dout_d = b8_q ? (2*DW)'({rlo_q[7:0], 8'hFF}) : {rlo_q, {DW{1'b1}}};
                v_d    = 1'b1;
            end else begin
                dout_d = b8_q ? (2*DW)'({r[7:0], q[7:0]}) : {r, q};
                v_d    = ovf_q | (sgn_q & sovf);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        last    = b8_q ? CW'(8 / RADIX - 1) : CW'(DW / RADIX - 1);
        if (cen) begin
            done_d = 1'b0;
            unique case (state_q)
                IDLE: if (mdu.start && !done_q) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
                RUN: if (skip_q) begin
                    state_d = FIX;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == last) state_d = FIX;
                end
                FIX: begin
                    fix     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            v_q     <= v_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
        if (load) begin
            div_q  <= in_div;
            sgn_q  <= in_sgn;
            b8_q   <= in_b8;
            neg_q  <= in_div ? (sd ^ sb) : (sa ^ sb);
            rneg_q <= sd;
            ovf_q  <= dhi >= mb;
            dz_q   <= mb == '0;
            skip_q <= in_div ? (mb == '0) : MUL_SKIP;
            rlo_q  <= fit_w(mdu.op0[DW-1:0], in_b8);
        end
    end

    assign mdu.busy = (state_q != IDLE) | done_q;
    assign mdu.done = done_q;
    assign mdu.dout = dout_q;
    assign mdu.v    = v_q;
endmodule

// File: tb/tb_jt900h_muldiv.sv
// Scoreboard bench for jt900h_muldiv: expected results are queued at each accepted start.
`timescale 1ns/1ps
module tb_jt900h_muldiv;
    localparam int DW = 16;

    typedef struct {
        string       tag;
        logic [31:0] dout;
        logic        v;
        bit          chk_dout;
        int          lat;
        int          lat_clk;
        int          t_cen;
        int          t_clk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b1;
    bit   cen_tog = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc_cen = 0;
    int   cyc_clk = 0;
    exp_t sbq[$];
    exp_t mon_e;
    logic done_prev = 1'b0;
    bit   pulse_pend = 1'b0;
    bit   pulse_exp = 1'b0;

    jt900h_muldiv_if #(.DW(DW)) mdu();

    jt900h_muldiv #(.DW(DW), .RADIX(1)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .mdu (mdu)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_clk++;
        if (cen) cyc_cen++;
    end

    always @(negedge clk) cen = cen_tog ? ~cen : 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic b8, input logic [31:0] a,
                                   input logic [15:0] b);
        exp_t   e;
        longint one = 1;
        int     w   = b8 ? 8 : 16;
        longint mw  = (one << w) - 1;
        longint m2  = (one << (2 * w)) - 1;
        longint x, y, q, r;
        e.tag = ""; e.lat_clk = 0; e.t_cen = 0; e.t_clk = 0;
        e.chk_dout = 1'b1; e.v = 1'b0;
        if (!op[1]) begin
            x = longint'(a) & mw;
            y = longint'(b) & mw;
            if (op[0]) begin
                if (x > (mw >> 1)) x -= (one << w);
                if (y > (mw >> 1)) y -= (one << w);
            end
            e.dout = 32'((x * y) & m2);
`ifdef JT900H_MULDIV_FAST_EN
            e.lat = 2;
`else
            e.lat = w + 1;
`endif
        end else begin
            x = longint'(a) & m2;
            y = longint'(b) & mw;
            if (op[0]) begin
                if (x > (m2 >> 1)) x -= (one << (2 * w));
                if (y > (mw >> 1)) y -= (one << w);
            end
            if (y == 0) begin
                e.v    = 1'b1;
                e.dout = 32'(((longint'(a) & mw) << w) | mw);
                e.lat  = 2;
            end else begin
                q = x / y;
                r = x % y;
                if (op[0]) e.v = (q < -(one << (w - 1))) || (q > (one << (w - 1)) - 1);
                else       e.v = q > mw;
                e.dout     = 32'(((r & mw) << w) | (q & mw));
                e.chk_dout = !e.v;
                e.lat      = w + 1;
            end
        end
        return e;
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((sbq.size() != 0 || mdu.busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, 64'(sbq.size()), 64'd0);
        sbq.delete();
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic b8,
                         input logic [31:0] a, input logic [15:0] b, input bit wait_done);
        exp_t e;
        e = model(op, b8, a, b);
        e.tag     = tag;
        e.lat_clk = cen_tog ? 2 * e.lat : 0;
        mdu.op      = op;
        mdu.byte_op = b8;
        mdu.op0     = a;
        mdu.op1     = b;
        mdu.start   = 1'b1;
        do @(posedge clk); while (cen !== 1'b1);
        #1;
        e.t_cen = cyc_cen;
        e.t_clk = cyc_clk;
        sbq.push_back(e);
        mdu.start   = 1'b0;
        mdu.op      = 2'($urandom);
        mdu.byte_op = 1'($urandom);
        mdu.op0     = $urandom;
        mdu.op1     = 16'($urandom);
        if (wait_done) wait_idle(tag);
    endtask

    always @(negedge clk) begin
        if (pulse_pend) begin
            chk({mon_e.tag, "_done_hold"}, 64'(mdu.done), 64'(pulse_exp));
            pulse_pend = 1'b0;
        end
        if (mdu.done && !done_prev) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.chk_dout) chk({mon_e.tag, "_dout"}, 64'(mdu.dout), 64'(mon_e.dout));
                chk({mon_e.tag, "_v"}, 64'(mdu.v), 64'(mon_e.v));
                chk({mon_e.tag, "_lat"}, 64'(cyc_cen - mon_e.t_cen), 64'(mon_e.lat));
                if (mon_e.lat_clk != 0)
                    chk({mon_e.tag, "_lat_clk"}, 64'(cyc_clk - mon_e.t_clk), 64'(mon_e.lat_clk));
                chk({mon_e.tag, "_busy"}, 64'(mdu.busy), 64'd1);
                pulse_pend = 1'b1;
                pulse_exp  = cen_tog;
            end
        end
        done_prev = mdu.done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rop;
        logic        rb8;
        logic [31:0] ra;
        logic [15:0] rb;
        mdu.start   = 1'b0;
        mdu.op      = 2'b00;
        mdu.byte_op = 1'b0;
        mdu.op0     = '0;
        mdu.op1     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(mdu.busy), 64'd0);
        chk("rst_done", 64'(mdu.done), 64'd0);
        chk("rst_dout", 64'(mdu.dout), 64'd0);
        chk("rst_v",    64'(mdu.v),    64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue("mul_b",    2'b00, 1'b1, 32'h00000012, 16'h0034, 1'b1);
        issue("muls_b",   2'b01, 1'b1, 32'h000000FF, 16'h0002, 1'b1);
        issue("muls_w",   2'b01, 1'b0, 32'h00008000, 16'h8000, 1'b1);
        issue("mul_wmax", 2'b00, 1'b0, 32'h0000FFFF, 16'hFFFF, 1'b1);
        issue("div_w",    2'b10, 1'b0, 32'h00012345, 16'h0100, 1'b1);
        issue("divs_b",   2'b11, 1'b1, 32'h0000FFF9, 16'h0002, 1'b1);
        issue("div_ovf",  2'b10, 1'b1, 32'h00001234, 16'h0010, 1'b1);
        issue("divs_min", 2'b11, 1'b0, 32'hFFFF8000, 16'h0001, 1'b1);
        issue("divs_pov", 2'b11, 1'b0, 32'h00008000, 16'h0001, 1'b1);
        issue("divs_wov", 2'b11, 1'b0, 32'h80000000, 16'hFFFF, 1'b1);
        issue("div_z",    2'b10, 1'b1, 32'h00001234, 16'h0000, 1'b1);

        // reset in the middle of RUN abandons the operation
        issue("rst_mid", 2'b10, 1'b0, 32'h00012345, 16'h0100, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_busy", 64'(mdu.busy), 64'd0);
        chk("rstmid_dout", 64'(mdu.dout), 64'd0);
        chk("rstmid_v",    64'(mdu.v),    64'd0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue("after_rst", 2'b00, 1'b1, 32'h00000012, 16'h0034, 1'b1);

        // start pulsed while busy must be ignored
        issue("run_ign", 2'b10, 1'b0, 32'h00012345, 16'h0100, 1'b0);
        repeat (3) @(negedge clk);
        mdu.start = 1'b1;
        mdu.op    = 2'b00;
        mdu.op0   = 32'h00000007;
        mdu.op1   = 16'h0003;
        @(negedge clk);
        mdu.start = 1'b0;
        wait_idle("run_ign");

        // cen toggling: latency in clock edges doubles, done stretches
        @(negedge clk);
        #2 cen_tog = 1'b1;
        issue("cen_mul", 2'b00, 1'b1, 32'h00000012, 16'h0034, 1'b1);
        issue("cen_divs", 2'b11, 1'b1, 32'h0000FFF9, 16'h0002, 1'b1);
        #2 cen_tog = 1'b0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom);
            rb8 = 1'($urandom);
            ra  = $urandom;
            rb  = 16'($urandom);
            if (rop[1] && (i % 2 == 0)) begin
                if (rb8) ra[15:8]  = 8'(ra[15:8] % (rb[7:0] | 8'h01));
                else     ra[31:16] = ra[31:16] % (rb | 16'h0001);
            end
            issue("rnd", rop, rb8, ra, rb, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
